// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 16x8 register file: turns valid/ready write and
// dual-read requests into EN/WR pin activity and returns read operands on a response channel.
module regfile_access_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rf_en,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_dout1,
  input  logic [DATA_W-1:0] rf_dout2
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdAddr,
    StRdWait,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic                rf_en_q, rf_en_d;
  logic                rf_wr_q, rf_wr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]   raddr1_q, raddr1_d;
  logic [ADDR_W-1:0]   raddr2_q, raddr2_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rf_en_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
    end else begin
      state_q     <= state_d;
      rf_en_q     <= rf_en_d;
      rf_wr_q     <= rf_wr_d;
      rsp_valid_q <= rsp_valid_d;
      raddr1_q    <= raddr1_d;
      raddr2_q    <= raddr2_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rf_en_d     = rf_en_q;
    rf_wr_d     = rf_wr_q;
    rsp_valid_d = rsp_valid_q;
    raddr1_d    = raddr1_q;
    raddr2_d    = raddr2_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rf_en_d = 1'b1;
          if (req_wr) begin
            state_d = StWrite;
            rf_wr_d = 1'b1;
            waddr_d = req_addr1;
            wdata_d = req_wdata;
          end else begin
            state_d  = StRdAddr;
            rf_wr_d  = 1'b0;
            raddr1_d = req_addr1;
            raddr2_d = req_addr2;
          end
        end
      end
      StWrite: begin
        // Register file commits on this edge; drop the strobe straight away.
        state_d = StIdle;
        rf_en_d = 1'b0;
        rf_wr_d = 1'b0;
      end
      StRdAddr: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        // Addresses have been stable a full cycle, so both comb and registered
        // register-file reads are settled here.
        state_d     = StResp;
        rdata1_d    = rf_dout1;
        rdata2_d    = rf_dout2;
        rsp_valid_d = 1'b1;
        rf_en_d     = 1'b0;
        rf_wr_d     = 1'b0;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        rf_en_d = 1'b0;
        rf_wr_d = 1'b0;
      end
    endcase
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data1     = rdata1_q;
  assign rsp_data2     = rdata2_q;
  assign rf_en         = rf_en_q;
  assign rf_wr         = rf_wr_q;
  assign rf_read_addr1 = raddr1_q;
  assign rf_read_addr2 = raddr2_q;
  assign rf_write_addr = waddr_q;
  assign rf_write_data = wdata_q;

endmodule
